// File: rtl/wrapper_host_driver.sv
// wrapper_host_driver: host-side initiator that streams a frame into the network wrapper, issues the info command and collects the result
module wrapper_host_driver #(
  parameter int DATA_W = 19,
  parameter int RES_W = 4,
  parameter int MAX_WORDS = 128,
  parameter int TIMEOUT = 1024,
  parameter int TO_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        read_len_i,
  input  logic [7:0]        count_len_i,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_data_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  output logic [1:0]        opcode_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [RES_W-1:0]  result_i,
  input  logic [1:0]        status_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [RES_W-1:0]  result_o,
  output logic [1:0]        err_o,
  output logic              trunc_o
);
  typedef enum logic [2:0] {IDLE, PRE_WAIT, WRITE, INFO, WAIT_BUSY, WAIT_DONE, DONE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_rd, r_cnt, r_wc;
  logic [TO_W-1:0] r_to;
  logic [8:0] w_sum;
  logic w_hs, w_bad, w_full, w_wait, w_exit, w_to_hit;
  assign w_hs = r_state == WRITE && word_valid_i;
  assign w_sum = {1'b0, read_len_i} + {1'b0, count_len_i};
  assign w_bad = w_sum == 9'd0 || w_sum[8];
  assign w_full = r_wc == 8'(MAX_WORDS - 1);
  assign w_wait = r_state inside {PRE_WAIT, WAIT_BUSY, WAIT_DONE};
  assign w_exit = r_state == WAIT_BUSY ? status_i == 2'd1 : status_i != 2'd1;
  assign w_to_hit = w_wait && !w_exit && r_to == TO_W'(TIMEOUT - 1);
  assign word_ready_o = r_state == WRITE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = !start_i ? IDLE : w_bad ? DONE : status_i == 2'd1 ? PRE_WAIT : WRITE;
      PRE_WAIT:  w_next = w_exit ? WRITE : w_to_hit ? DONE : PRE_WAIT;
      WRITE:     w_next = w_hs && (word_last_i || w_full) ? INFO : WRITE;
      INFO:      w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = w_exit ? WAIT_DONE : w_to_hit ? DONE : WAIT_BUSY;
      WAIT_DONE: w_next = w_exit || w_to_hit ? DONE : WAIT_DONE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_o <= 2'd0;
      data_o <= '0;
      result_o <= '0;
      err_o <= 2'd0;
      trunc_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      r_rd <= 8'd0;
      r_cnt <= 8'd0;
      r_wc <= 8'd0;
      r_to <= '0;
    end else begin
      opcode_o <= w_hs ? 2'd1 : r_state == INFO ? 2'd2 : 2'd0;
      data_o <= w_hs ? word_data_i : r_state == INFO ? DATA_W'({r_cnt, 2'b00, r_rd}) : '0;
      r_wc <= r_state != WRITE ? 8'd0 : r_wc + 8'(w_hs);
      r_to <= w_next != r_state ? '0 : r_to + 1'b1;
      busy_o <= w_next != IDLE;
      done_o <= r_state == DONE;
      if (r_state == IDLE && start_i) begin
        r_rd <= read_len_i;
        r_cnt <= count_len_i;
        err_o <= w_bad ? 2'd1 : 2'd0;
        trunc_o <= 1'b0;
      end
      if (w_hs && w_full && !word_last_i) trunc_o <= 1'b1;
      if (w_to_hit) err_o <= 2'd2;
      if (r_state == WAIT_DONE && w_exit) begin
        err_o <= status_i == 2'd2 ? 2'd0 : 2'd3;
        if (status_i == 2'd2) result_o <= result_i;
      end
    end
  end
endmodule

// File: tb/tb_wrapper_host_driver.sv
// tb_wrapper_host_driver: self-checking bench with a behavioural wrapper model and randomized frames
module tb_wrapper_host_driver;
  localparam int DATA_W = 19;
  localparam int RES_W = 4;
  localparam int TIMEOUT = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic [7:0] read_len_i = 8'd0;
  logic [7:0] count_len_i = 8'd0;
  logic word_valid_i = 1'b0;
  logic [DATA_W-1:0] word_data_i = '0;
  logic word_last_i = 1'b0;
  logic word_ready_o;
  logic [1:0] opcode_o;
  logic [DATA_W-1:0] data_o;
  logic [RES_W-1:0] result_i;
  logic [1:0] status_i;
  logic busy_o, done_o, trunc_o;
  logic [RES_W-1:0] result_o;
  logic [1:0] err_o;
  logic wm_force = 1'b0;
  logic wm_respond = 1'b1;
  logic [1:0] wm_status = 2'd0;
  logic [1:0] wm_final = 2'd2;
  logic [RES_W-1:0] wm_result = '0;
  int wm_cnt = 0;
  int wm_len = 1;
  int n_chk = 0, n_err = 0;
  int n_wr = 0, n_info = 0, n_done = 0, n_dz = 0, cyc = 0, t_info = 0, t_done = 0;
  logic [DATA_W-1:0] wlog [0:4095];
  logic [DATA_W-1:0] info_d = '0;
  logic [DATA_W-1:0] frame [0:255];
  logic [RES_W-1:0] last_res = '0;
  assign status_i = wm_force ? 2'd1 : wm_status;
  assign result_i = wm_result;
  always #5 clk = ~clk;
  wrapper_host_driver dut (
    .clk(clk), .rst(rst), .start_i(start_i), .read_len_i(read_len_i), .count_len_i(count_len_i),
    .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_last_i(word_last_i),
    .word_ready_o(word_ready_o), .opcode_o(opcode_o), .data_o(data_o), .result_i(result_i),
    .status_i(status_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .err_o(err_o),
    .trunc_o(trunc_o)
  );
  always @(posedge clk) begin
    if (wm_cnt > 0) begin
      wm_cnt <= wm_cnt - 1;
      if (wm_cnt == 1) wm_status <= wm_final;
    end else if (opcode_o == 2'd2 && wm_respond) begin
      wm_status <= 2'd1;
      wm_cnt <= wm_len;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (opcode_o == 2'd1) begin
      wlog[n_wr] = data_o;
      n_wr++;
    end
    if (opcode_o == 2'd2) begin
      n_info++;
      info_d = data_o;
      t_info = cyc;
    end
    if (opcode_o == 2'd0 && data_o != '0) n_dz++;
    if (done_o) begin
      n_done++;
      t_done = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) frame[i] = DATA_W'($urandom);
  endtask
  task automatic do_start(input logic [7:0] rd, input logic [7:0] cnt);
    read_len_i = rd;
    count_len_i = cnt;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    read_len_i = 8'($urandom);
    count_len_i = 8'($urandom);
  endtask
  task automatic send_words(input int n, input bit last, input int gmin, input int gmax, input int budget, output int acc);
    bit ok;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      word_data_i = frame[i];
      word_last_i = last && i == n - 1;
      word_valid_i = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
        @(negedge clk);
        ok = word_ready_o;
        step();
      end
      word_valid_i = 1'b0;
      word_last_i = 1'b0;
      if (!ok) break;
      acc++;
      repeat ($urandom_range(gmax, gmin)) step();
    end
  endtask
  task automatic wait_done(input int d0, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      step();
      got = n_done != d0;
    end
  endtask
  task automatic chk_writes(input string tag, input int w0, input int n);
    int bad;
    bad = 0;
    chk({tag, "_nwr"}, n_wr - w0, n);
    for (int k = 0; k < n; k++) if (wlog[w0 + k] !== frame[k]) bad++;
    chk({tag, "_wdata"}, bad, 0);
  endtask
  task automatic run_txn(input string tag, input int n, input int gmin, input int gmax,
                         input logic [7:0] rd, input logic [7:0] cnt, input logic [RES_W-1:0] res, input logic [1:0] fin);
    int w0, i0, d0, acc;
    bit got;
    logic [RES_W-1:0] exp_res;
    w0 = n_wr;
    i0 = n_info;
    d0 = n_done;
    exp_res = fin == 2'd2 ? res : last_res;
    wm_len = rd + cnt;
    wm_final = fin;
    wm_result = res;
    do_start(rd, cnt);
    send_words(n, 1'b1, gmin, gmax, 200, acc);
    wait_done(d0, 3000, got);
    chk({tag, "_acc"}, acc, n);
    chk({tag, "_done_seen"}, got, 1);
    chk_writes(tag, w0, n);
    chk({tag, "_ninfo"}, n_info - i0, 1);
    chk({tag, "_info"}, info_d, int'(cnt) * 1024 + int'(rd));
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_err"}, err_o, fin == 2'd2 ? 0 : 3);
    chk({tag, "_trunc"}, trunc_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ndone"}, n_done - d0, 1);
    last_res = exp_res;
  endtask
  task automatic cfg_err(input string tag, input logic [7:0] rd, input logic [7:0] cnt);
    int w0, i0;
    w0 = n_wr;
    i0 = n_info;
    do_start(rd, cnt);
    @(negedge clk);
    chk({tag, "_done_early"}, done_o, 0);
    chk({tag, "_busy_early"}, busy_o, 1);
    step();
    @(negedge clk);
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, 1);
    chk({tag, "_trunc"}, trunc_o, 0);
    step();
    chk({tag, "_nwr"}, n_wr - w0, 0);
    chk({tag, "_ninfo"}, n_info - i0, 0);
    chk({tag, "_result"}, result_o, last_res);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n, w0, i0, d0, acc;
    bit got;
    logic [7:0] rd, cnt;
    logic [RES_W-1:0] res;
    repeat (3) step();
    @(negedge clk);
    chk("rst_opcode", opcode_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_trunc", trunc_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", word_ready_o, 0);
    step();
    rst = 1'b0;
    step();
    fill(3);
    run_txn("basic", 3, 0, 0, 8'd5, 8'd10, 4'h7, 2'd2);
    fill(4);
    run_txn("gap", 4, 2, 2, 8'($urandom_range(30, 1)), 8'($urandom_range(30, 0)), RES_W'($urandom), 2'd2);
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(24, 1);
      rd = 8'($urandom_range(40, 0));
      cnt = 8'($urandom_range(40, 0));
      if (rd == 8'd0 && cnt == 8'd0) rd = 8'd1;
      fill(n);
      run_txn("rand", n, 0, 3, rd, cnt, RES_W'($urandom), 2'd2);
    end
    fill(130);
    w0 = n_wr;
    i0 = n_info;
    d0 = n_done;
    res = RES_W'($urandom);
    wm_len = 7;
    wm_final = 2'd2;
    wm_result = res;
    do_start(8'd3, 8'd4);
    send_words(130, 1'b0, 0, 0, 60, acc);
    chk("trunc_acc", acc, 128);
    chk("trunc_ready", word_ready_o, 0);
    wait_done(d0, 3000, got);
    chk("trunc_done_seen", got, 1);
    chk_writes("trunc", w0, 128);
    chk("trunc_flag", trunc_o, 1);
    chk("trunc_ninfo", n_info - i0, 1);
    chk("trunc_info", info_d, 4 * 1024 + 3);
    chk("trunc_err", err_o, 0);
    chk("trunc_result", result_o, res);
    last_res = res;
    cfg_err("cfg300", 8'd200, 8'd100);
    cfg_err("cfg0", 8'd0, 8'd0);
    cfg_err("cfg256", 8'd200, 8'd56);
    fill(2);
    run_txn("sum255", 2, 0, 1, 8'd255, 8'd0, RES_W'($urandom), 2'd2);
    fill(3);
    w0 = n_wr;
    d0 = n_done;
    res = RES_W'($urandom);
    wm_len = 9;
    wm_final = 2'd2;
    wm_result = res;
    wm_force = 1'b1;
    do_start(8'd4, 8'd5);
    word_valid_i = 1'b1;
    word_data_i = frame[0];
    repeat (20) step();
    @(negedge clk);
    chk("pre_nwr", n_wr - w0, 0);
    chk("pre_busy", busy_o, 1);
    chk("pre_ready", word_ready_o, 0);
    step();
    wm_force = 1'b0;
    send_words(3, 1'b1, 0, 0, 200, acc);
    wait_done(d0, 3000, got);
    chk("pre_acc", acc, 3);
    chk("pre_done_seen", got, 1);
    chk_writes("pre", w0, 3);
    chk("pre_err", err_o, 0);
    chk("pre_result", result_o, res);
    fill(10);
    d0 = n_done;
    do_start(8'd4, 8'd4);
    word_valid_i = 1'b1;
    word_data_i = frame[0];
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mrst_opcode", opcode_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_ready", word_ready_o, 0);
    chk("mrst_result", result_o, 0);
    step();
    rst = 1'b0;
    word_valid_i = 1'b0;
    last_res = '0;
    repeat (5) step();
    chk("mrst_ndone", n_done - d0, 0);
    chk("mrst_opcode_idle", opcode_o, 0);
    fill(2);
    run_txn("prior", 2, 0, 1, 8'd6, 8'd6, RES_W'($urandom_range(15, 1)), 2'd2);
    fill(3);
    run_txn("stat0", 3, 0, 1, 8'd6, 8'd6, RES_W'($urandom), 2'd0);
    fill(1);
    w0 = n_wr;
    i0 = n_info;
    d0 = n_done;
    wm_respond = 1'b0;
    do_start(8'd2, 8'd3);
    send_words(1, 1'b1, 0, 0, 200, acc);
    wait_done(d0, 2000, got);
    chk("tmo_done_seen", got, 1);
    chk("tmo_err", err_o, 2);
    chk("tmo_cycles", t_done - t_info, TIMEOUT + 1);
    chk("tmo_ninfo", n_info - i0, 1);
    chk("tmo_nwr", n_wr - w0, 1);
    wm_respond = 1'b1;
    chk("idle_data_zero", n_dz, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
